// File: rtl/mc_control_fsm.sv
// Multicycle control FSM for the RV32I core: sequences fetch/execute/load/store,
// traps on illegal opcodes and memory timeouts, and parks the core for debug at instruction boundaries.
module mc_control_fsm #(
  parameter int TIMEOUT_CYCLES = 256,
  parameter int TIMER_W        = 9,
  parameter int HALT_ON_RESET  = 0
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [6:0] opcode,
  input  logic       mem_ready,
  input  logic       halt_req,
  input  logic       resume_req,
  input  logic       step_req,
  output logic       mem_read,
  output logic       mem_write,
  output logic       addr_sel,
  output logic       rd_sel,
  output logic [1:0] alu_insel1,
  output logic [1:0] alu_insel2,
  output logic       write_ir,
  output logic       write_rd,
  output logic       write_pc,
  output logic       pc_sel,
  output logic       trap,
  output logic [1:0] trap_cause,
  output logic       halted,
  output logic [2:0] dbg_state
);

  typedef enum logic [2:0] {
    S_FETCH  = 3'd0,
    S_EXEC   = 3'd1,
    S_LD     = 3'd2,
    S_ST     = 3'd3,
    S_TRAP   = 3'd4,
    S_HALTED = 3'd5
  } state_e;

  localparam logic [6:0] OP_LUI     = 7'b0110111;
  localparam logic [6:0] OP_AUIPC   = 7'b0010111;
  localparam logic [6:0] OP_JAL     = 7'b1101111;
  localparam logic [6:0] OP_JALR    = 7'b1100111;
  localparam logic [6:0] OP_OPIMM   = 7'b0010011;
  localparam logic [6:0] OP_OP      = 7'b0110011;
  localparam logic [6:0] OP_BRANCH  = 7'b1100011;
  localparam logic [6:0] OP_MISCMEM = 7'b0001111;
  localparam logic [6:0] OP_SYSTEM  = 7'b1110011;
  localparam logic [6:0] OP_LOAD    = 7'b0000011;
  localparam logic [6:0] OP_STORE   = 7'b0100011;

  localparam logic [1:0] IN1_RS1  = 2'b00;
  localparam logic [1:0] IN1_PC   = 2'b01;
  localparam logic [1:0] IN1_ZERO = 2'b11;
  localparam logic [1:0] IN2_IMM  = 2'b01;
  localparam logic [1:0] IN2_FOUR = 2'b11;

  localparam logic [1:0] CAUSE_ILLEGAL = 2'b01;
  localparam logic [1:0] CAUSE_TIMEOUT = 2'b10;

  localparam bit WD_EN = (TIMEOUT_CYCLES != 0);
  localparam int TO_LAST_I = (TIMEOUT_CYCLES > 0) ? TIMEOUT_CYCLES - 1 : 0;
  localparam logic [TIMER_W-1:0] TO_LAST = TO_LAST_I[TIMER_W-1:0];

  state_e             state_q, state_d;
  logic [TIMER_W-1:0] timer_q, timer_d;
  logic [1:0]         cause_q, cause_d;
  logic               step_q, step_d;

  logic       mem_read_c, mem_write_c, addr_sel_c, rd_sel_c;
  logic [1:0] alu_insel1_c, alu_insel2_c;
  logic       write_ir_c, write_rd_c, write_pc_c, pc_sel_c, trap_c, halted_c;
  logic       wd_expired;
  state_e     boundary_state;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= (HALT_ON_RESET != 0) ? S_HALTED : S_FETCH;
      timer_q <= '0;
      cause_q <= 2'b00;
      step_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      timer_q <= timer_d;
      cause_q <= cause_d;
      step_q  <= step_d;
    end
  end

  // Memory handshake: mem_read/mem_write act as valid and, together with the
  // address select, stay constant until mem_ready is sampled high in the same
  // cycle (the transfer completes then) or the watchdog expires (request drops
  // on the next cycle). mem_ready while no request is raised has no effect.
  always_comb begin
    state_d      = state_q;
    timer_d      = '0;
    cause_d      = cause_q;
    step_d       = step_q;
    mem_read_c   = 1'b0;
    mem_write_c  = 1'b0;
    addr_sel_c   = 1'b0;
    rd_sel_c     = 1'b0;
    alu_insel1_c = IN1_RS1;
    alu_insel2_c = 2'b00;
    write_ir_c   = 1'b0;
    write_rd_c   = 1'b0;
    write_pc_c   = 1'b0;
    pc_sel_c     = 1'b0;
    trap_c       = 1'b0;
    halted_c     = 1'b0;
    wd_expired     = WD_EN && (timer_q == TO_LAST);
    boundary_state = (halt_req || step_q) ? S_HALTED : S_FETCH;

    case (state_q)
      S_FETCH: begin
        mem_read_c = 1'b1;
        addr_sel_c = 1'b1;
        if (mem_ready) begin
          write_ir_c = 1'b1;
          state_d    = S_EXEC;
        end else if (wd_expired) begin
          state_d = S_TRAP;
          cause_d = CAUSE_TIMEOUT;
        end else begin
          timer_d = timer_q + TIMER_W'(1);
        end
      end
      S_EXEC: begin
        state_d = boundary_state;
        case (opcode)
          OP_LUI: begin
            alu_insel1_c = IN1_ZERO;
            alu_insel2_c = IN2_IMM;
            write_rd_c   = 1'b1;
            write_pc_c   = 1'b1;
          end
          OP_AUIPC: begin
            alu_insel1_c = IN1_PC;
            alu_insel2_c = IN2_IMM;
            write_rd_c   = 1'b1;
            write_pc_c   = 1'b1;
          end
          OP_JAL, OP_JALR: begin
            alu_insel1_c = IN1_PC;
            alu_insel2_c = IN2_FOUR;
            write_rd_c   = 1'b1;
            write_pc_c   = 1'b1;
          end
          OP_OPIMM: begin
            alu_insel2_c = IN2_IMM;
            write_rd_c   = 1'b1;
            write_pc_c   = 1'b1;
          end
          OP_OP: begin
            write_rd_c = 1'b1;
            write_pc_c = 1'b1;
          end
          OP_BRANCH, OP_MISCMEM, OP_SYSTEM: write_pc_c = 1'b1;
          OP_LOAD:  state_d = S_LD;
          OP_STORE: state_d = S_ST;
          // Every listed opcode ends in 2'b11, so compressed encodings land here too.
          default: begin
            state_d = S_TRAP;
            cause_d = CAUSE_ILLEGAL;
          end
        endcase
      end
      S_LD: begin
        mem_read_c   = 1'b1;
        alu_insel2_c = IN2_IMM;
        if (mem_ready) begin
          write_rd_c = 1'b1;
          rd_sel_c   = 1'b1;
          write_pc_c = 1'b1;
          state_d    = boundary_state;
        end else if (wd_expired) begin
          state_d = S_TRAP;
          cause_d = CAUSE_TIMEOUT;
        end else begin
          timer_d = timer_q + TIMER_W'(1);
        end
      end
      S_ST: begin
        mem_write_c  = 1'b1;
        alu_insel2_c = IN2_IMM;
        if (mem_ready) begin
          write_pc_c = 1'b1;
          state_d    = boundary_state;
        end else if (wd_expired) begin
          state_d = S_TRAP;
          cause_d = CAUSE_TIMEOUT;
        end else begin
          timer_d = timer_q + TIMER_W'(1);
        end
      end
      S_TRAP: begin
        trap_c     = 1'b1;
        write_pc_c = 1'b1;
        pc_sel_c   = 1'b1;
        state_d    = boundary_state;
      end
      S_HALTED: begin
        halted_c = 1'b1;
        if (step_req) begin
          state_d = S_FETCH;
          step_d  = 1'b1;
        end else if (resume_req) begin
          state_d = S_FETCH;
        end
      end
      default: state_d = S_FETCH;
    endcase

    if (state_d == S_HALTED) step_d = 1'b0;
  end

  // Strobes are masked while rst_n is low so a reset mid-transfer drops the request at once.
  assign mem_read   = mem_read_c & rst_n;
  assign mem_write  = mem_write_c & rst_n;
  assign addr_sel   = addr_sel_c & rst_n;
  assign rd_sel     = rd_sel_c & rst_n;
  assign alu_insel1 = alu_insel1_c & {2{rst_n}};
  assign alu_insel2 = alu_insel2_c & {2{rst_n}};
  assign write_ir   = write_ir_c & rst_n;
  assign write_rd   = write_rd_c & rst_n;
  assign write_pc   = write_pc_c & rst_n;
  assign pc_sel     = pc_sel_c & rst_n;
  assign trap       = trap_c & rst_n;
  assign halted     = halted_c & rst_n;
  assign trap_cause = cause_q;
  assign dbg_state  = state_q;

endmodule

// File: tb/tb_mc_control_fsm.sv
// Bench for mc_control_fsm: per-cycle expected output vectors are queued as stimulus is
// applied and compared against the packed DUT outputs just before the next rising edge.
module tb_mc_control_fsm;

  localparam logic [6:0] OP_LUI    = 7'b0110111;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_OPIMM  = 7'b0010011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [6:0] opcode;
  logic       mem_ready, halt_req, resume_req, step_req;

  logic       m_mr, m_mw, m_as, m_rs, m_wir, m_wrd, m_wpc, m_ps, m_tr, m_h;
  logic [1:0] m_i1, m_i2, m_tc;
  logic [2:0] m_dbg;
  logic       h_mr, h_mw, h_as, h_rs, h_wir, h_wrd, h_wpc, h_ps, h_tr, h_h;
  logic [1:0] h_i1, h_i2, h_tc;
  logic [2:0] h_dbg;

  logic [15:0] exp_q[$];
  logic [1:0]  cause;
  int          checks = 0;
  int          failures = 0;

  always #5 clk = ~clk;

  mc_control_fsm #(.TIMEOUT_CYCLES(4), .TIMER_W(3), .HALT_ON_RESET(0)) dut (
    .clk(clk), .rst_n(rst_n), .opcode(opcode), .mem_ready(mem_ready),
    .halt_req(halt_req), .resume_req(resume_req), .step_req(step_req),
    .mem_read(m_mr), .mem_write(m_mw), .addr_sel(m_as), .rd_sel(m_rs),
    .alu_insel1(m_i1), .alu_insel2(m_i2), .write_ir(m_wir), .write_rd(m_wrd),
    .write_pc(m_wpc), .pc_sel(m_ps), .trap(m_tr), .trap_cause(m_tc),
    .halted(m_h), .dbg_state(m_dbg)
  );

  mc_control_fsm #(.HALT_ON_RESET(1)) dut_h (
    .clk(clk), .rst_n(rst_n), .opcode(opcode), .mem_ready(mem_ready),
    .halt_req(halt_req), .resume_req(resume_req), .step_req(step_req),
    .mem_read(h_mr), .mem_write(h_mw), .addr_sel(h_as), .rd_sel(h_rs),
    .alu_insel1(h_i1), .alu_insel2(h_i2), .write_ir(h_wir), .write_rd(h_wrd),
    .write_pc(h_wpc), .pc_sel(h_ps), .trap(h_tr), .trap_cause(h_tc),
    .halted(h_h), .dbg_state(h_dbg)
  );

  wire [15:0] obs_m = {m_mr, m_mw, m_as, m_rs, m_i1, m_i2, m_wir, m_wrd, m_wpc, m_ps, m_tr, m_tc, m_h};
  wire [15:0] obs_h = {h_mr, h_mw, h_as, h_rs, h_i1, h_i2, h_wir, h_wrd, h_wpc, h_ps, h_tr, h_tc, h_h};

  // Vector layout: mr mw as rs i1[2] i2[2] wir wrd wpc ps tr tc[2] h
  function automatic logic [15:0] e_fetch(input logic rdy);
    return {1'b1, 1'b0, 1'b1, 1'b0, 2'b00, 2'b00, rdy, 1'b0, 1'b0, 1'b0, 1'b0, cause, 1'b0};
  endfunction

  function automatic logic [15:0] e_exec(input logic [1:0] i1, input logic [1:0] i2,
                                         input logic wrd, input logic wpc);
    return {1'b0, 1'b0, 1'b0, 1'b0, i1, i2, 1'b0, wrd, wpc, 1'b0, 1'b0, cause, 1'b0};
  endfunction

  function automatic logic [15:0] e_ld(input logic rdy);
    return {1'b1, 1'b0, 1'b0, rdy, 2'b00, 2'b01, 1'b0, rdy, rdy, 1'b0, 1'b0, cause, 1'b0};
  endfunction

  function automatic logic [15:0] e_st(input logic rdy);
    return {1'b0, 1'b1, 1'b0, 1'b0, 2'b00, 2'b01, 1'b0, 1'b0, rdy, 1'b0, 1'b0, cause, 1'b0};
  endfunction

  function automatic logic [15:0] e_trap();
    return {1'b0, 1'b0, 1'b0, 1'b0, 2'b00, 2'b00, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, cause, 1'b0};
  endfunction

  function automatic logic [15:0] e_halt();
    return {1'b0, 1'b0, 1'b0, 1'b0, 2'b00, 2'b00, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, cause, 1'b1};
  endfunction

  task automatic check_eq(input string tag, input logic [15:0] got, input logic [15:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  // One clock cycle with the inputs already applied; debug pulses are cleared afterwards.
  task automatic cyc(input string tag, input logic [15:0] e, input bit use_h);
    logic [15:0] got;
    exp_q.push_back(e);
    @(negedge clk);
    got = use_h ? obs_h : obs_m;
    check_eq(tag, got, exp_q.pop_front());
    @(posedge clk);
    #1;
    resume_req = 1'b0;
    step_req   = 1'b0;
  endtask

  initial begin
    rst_n = 1'b0; opcode = OP_OPIMM; mem_ready = 1'b0;
    halt_req = 1'b0; resume_req = 1'b0; step_req = 1'b0; cause = 2'b00;
    @(posedge clk);
    #1;
    cyc("rst_low", e_exec(2'b00, 2'b00, 1'b0, 1'b0), 0);
    rst_n = 1'b1;

    // Single-cycle instructions back to back with ready always high
    mem_ready = 1'b1;
    cyc("a_fetch_addi", e_fetch(1'b1), 0);
    cyc("a_exec_addi", e_exec(2'b00, 2'b01, 1'b1, 1'b1), 0);
    opcode = OP_LUI;
    cyc("a_fetch_lui", e_fetch(1'b1), 0);
    cyc("a_exec_lui", e_exec(2'b11, 2'b01, 1'b1, 1'b1), 0);
    opcode = OP_JAL;
    cyc("a_fetch_jal", e_fetch(1'b1), 0);
    cyc("a_exec_jal", e_exec(2'b01, 2'b11, 1'b1, 1'b1), 0);
    opcode = OP_BRANCH;
    cyc("a_fetch_br", e_fetch(1'b1), 0);
    cyc("a_exec_br", e_exec(2'b00, 2'b00, 1'b0, 1'b1), 0);

    // Load with ready three cycles late (lands on the last watchdog cycle)
    opcode = OP_LOAD;
    cyc("b_fetch", e_fetch(1'b1), 0);
    mem_ready = 1'b0;
    cyc("b_exec", e_exec(2'b00, 2'b00, 1'b0, 1'b0), 0);
    for (int i = 0; i < 3; i++) cyc("b_ld_wait", e_ld(1'b0), 0);
    mem_ready = 1'b1;
    cyc("b_ld_done", e_ld(1'b1), 0);

    // Store never acknowledged: watchdog trap
    opcode = OP_STORE;
    cyc("c_fetch", e_fetch(1'b1), 0);
    mem_ready = 1'b0;
    cyc("c_exec", e_exec(2'b00, 2'b00, 1'b0, 1'b0), 0);
    for (int i = 0; i < 4; i++) cyc("c_st_wait", e_st(1'b0), 0);
    cause = 2'b10;
    cyc("c_trap", e_trap(), 0);

    // Store acknowledged on the final watchdog cycle: no trap
    mem_ready = 1'b1;
    cyc("c2_fetch", e_fetch(1'b1), 0);
    mem_ready = 1'b0;
    cyc("c2_exec", e_exec(2'b00, 2'b00, 1'b0, 1'b0), 0);
    for (int i = 0; i < 3; i++) cyc("c2_st_wait", e_st(1'b0), 0);
    mem_ready = 1'b1;
    cyc("c2_st_done", e_st(1'b1), 0);

    // Illegal opcodes: all-zero and unlisted with low bits 10
    opcode = 7'b0000000;
    cyc("d_fetch", e_fetch(1'b1), 0);
    cyc("d_exec_zero", e_exec(2'b00, 2'b00, 1'b0, 1'b0), 0);
    cause = 2'b01;
    cyc("d_trap_zero", e_trap(), 0);
    opcode = 7'b0110110;
    cyc("d_fetch2", e_fetch(1'b1), 0);
    cyc("d_exec_bad", e_exec(2'b00, 2'b00, 1'b0, 1'b0), 0);
    cyc("d_trap_bad", e_trap(), 0);

    // Instruction fetch timeout
    mem_ready = 1'b0;
    for (int i = 0; i < 4; i++) cyc("e_fetch_wait", e_fetch(1'b0), 0);
    cause = 2'b10;
    cyc("e_trap", e_trap(), 0);

    // Halt during load wait, then single-step and resume variants
    opcode = OP_LOAD; mem_ready = 1'b1;
    cyc("f_fetch", e_fetch(1'b1), 0);
    mem_ready = 1'b0;
    cyc("f_exec", e_exec(2'b00, 2'b00, 1'b0, 1'b0), 0);
    halt_req = 1'b1;
    for (int i = 0; i < 2; i++) cyc("f_ld_wait", e_ld(1'b0), 0);
    mem_ready = 1'b1;
    cyc("f_ld_done", e_ld(1'b1), 0);
    cyc("f_halted", e_halt(), 0);
    cyc("f_halted_hold", e_halt(), 0);
    halt_req = 1'b0; step_req = 1'b1; opcode = OP_OPIMM;
    cyc("f_step_req", e_halt(), 0);
    cyc("f_step_fetch", e_fetch(1'b1), 0);
    cyc("f_step_exec", e_exec(2'b00, 2'b01, 1'b1, 1'b1), 0);
    cyc("f_step_rehalt", e_halt(), 0);
    cyc("f_idle_halt", e_halt(), 0);
    resume_req = 1'b1; step_req = 1'b1;
    cyc("f_both_req", e_halt(), 0);
    cyc("f_both_fetch", e_fetch(1'b1), 0);
    cyc("f_both_exec", e_exec(2'b00, 2'b01, 1'b1, 1'b1), 0);
    cyc("f_both_rehalt", e_halt(), 0);
    halt_req = 1'b1; resume_req = 1'b1;
    cyc("f_res_held", e_halt(), 0);
    cyc("f_res_fetch", e_fetch(1'b1), 0);
    cyc("f_res_exec", e_exec(2'b00, 2'b01, 1'b1, 1'b1), 0);
    cyc("f_res_rehalt", e_halt(), 0);
    halt_req = 1'b0; resume_req = 1'b1;
    cyc("f_res_free", e_halt(), 0);
    cyc("f_free_fetch", e_fetch(1'b1), 0);
    cyc("f_free_exec", e_exec(2'b00, 2'b01, 1'b1, 1'b1), 0);

    // Reset in the middle of a store wait
    opcode = OP_STORE;
    cyc("g_fetch", e_fetch(1'b1), 0);
    mem_ready = 1'b0;
    cyc("g_exec", e_exec(2'b00, 2'b00, 1'b0, 1'b0), 0);
    for (int i = 0; i < 2; i++) cyc("g_st_wait", e_st(1'b0), 0);
    rst_n = 1'b0;
    cyc("g_rst_mid_st", e_exec(2'b00, 2'b00, 1'b0, 1'b0), 0);
    rst_n = 1'b1; cause = 2'b00;
    cyc("g_fetch_after_rst", e_fetch(1'b0), 0);

    // Halt-on-reset instance: parked until resume
    cyc("h_halted", e_halt(), 1);
    cyc("h_halted_hold", e_halt(), 1);
    resume_req = 1'b1;
    cyc("h_resume", e_halt(), 1);
    cyc("h_fetch", e_fetch(1'b0), 1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
